// File: rtl/deck_pkg.sv
// Shared types and constants for the card-deck controller slice.
package deck_pkg;

   localparam int unsigned DECK_SIZE = 52;
   localparam logic [5:0]  CARD_NONE = 6'h3F;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_SHUF_START,
      ST_SHUF_WAIT,
      ST_SHUF_RUN,
      ST_READ,
      ST_WAIT,
      ST_DELIVER
   } deck_state_t;

   typedef enum logic {
      REQ_PLAYER = 1'b0,
      REQ_DEALER = 1'b1
   } req_id_t;

endpackage

// File: rtl/deck_rr_arbiter.sv
// Two-way round-robin grant between player and dealer draw requests.
module deck_rr_arbiter (
   input  logic Clock,
   input  logic resetn,
   input  logic req_player,
   input  logic req_dealer,
   input  logic update,
   output logic grant
);
   import deck_pkg::*;

   req_id_t last;
   req_id_t pick;

   always_comb begin
      pick = last;
      if (req_player && req_dealer)
         pick = (last == REQ_DEALER) ? REQ_PLAYER : REQ_DEALER;
      else if (req_player)
         pick = REQ_PLAYER;
      else if (req_dealer)
         pick = REQ_DEALER;
   end

   always_ff @(posedge Clock) begin
      if (!resetn)
         last <= REQ_DEALER;
      else if (update)
         last <= pick;
   end

   assign grant = pick;

endmodule

// File: rtl/deck_controller.sv
// Deck RAM owner: identity init, shuffle hand-off and round-robin card draws.
module deck_controller #(
   parameter int unsigned DECK_SIZE      = deck_pkg::DECK_SIZE,
   parameter int unsigned AUTO_RESHUFFLE = 1
) (
   input  logic       Clock,
   input  logic       resetn,
   input  logic       shuf_req,
   output logic       shuf_start,
   input  logic       shuf_on,
   input  logic [5:0] shuf_adr,
   input  logic [5:0] shuf_din,
   input  logic       shuf_we,
   input  logic       req_player,
   input  logic       req_dealer,
   output logic       ack_player,
   output logic       ack_dealer,
   output logic [5:0] card_out,
   output logic       card_valid,
   output logic [5:0] ram_adr,
   output logic [5:0] ram_din,
   output logic       ram_we,
   input  logic [5:0] ram_dout,
   output logic       ready,
   output logic       deck_empty,
   output logic [5:0] cards_left
);
   import deck_pkg::*;

   localparam logic [5:0] LAST_ADR = 6'(DECK_SIZE - 1);
   localparam logic [5:0] FULL_PTR = 6'(DECK_SIZE);

   deck_state_t state, state_nxt;
   logic [5:0]  init_cnt;
   logic [5:0]  ptr, ptr_nxt;
   logic [5:0]  card_q, left_q;
   logic        empty_q;
   logic        gnt, arb_update;
   req_id_t     gnt_q;
   logic        any_req, take_shuf, eng_sel;

   deck_rr_arbiter u_arb (
      .Clock      (Clock),
      .resetn     (resetn),
      .req_player (req_player),
      .req_dealer (req_dealer),
      .update     (arb_update),
      .grant      (gnt)
   );

   assign any_req   = req_player | req_dealer;
   assign take_shuf = shuf_req | ((AUTO_RESHUFFLE != 0) & empty_q);

   always_comb begin
      state_nxt  = state;
      arb_update = 1'b0;
      case (state)
         ST_INIT:       if (init_cnt == LAST_ADR) state_nxt = ST_IDLE;
         ST_IDLE: begin
            if (take_shuf)
               state_nxt = ST_SHUF_START;
            else if (any_req && !empty_q) begin
               state_nxt  = ST_READ;
               arb_update = 1'b1;
            end
         end
         ST_SHUF_START: state_nxt = ST_SHUF_WAIT;
         ST_SHUF_WAIT:  if (shuf_on) state_nxt = ST_SHUF_RUN;
         ST_SHUF_RUN:   if (!shuf_on) state_nxt = ST_IDLE;
         ST_READ:       state_nxt = ST_WAIT;
         ST_WAIT:       state_nxt = ST_DELIVER;
         ST_DELIVER:    state_nxt = ST_IDLE;
         default:       state_nxt = ST_INIT;
      endcase
   end

   always_comb begin
      ptr_nxt = ptr;
      if (state == ST_SHUF_RUN && !shuf_on)
         ptr_nxt = '0;
      else if (state == ST_DELIVER && ptr != FULL_PTR)
         ptr_nxt = ptr + 6'd1;
   end

   // Engine bus and write strobes drop as soon as resetn falls, not at the next edge.
   assign eng_sel = resetn && (state == ST_SHUF_START || state == ST_SHUF_WAIT ||
                               state == ST_SHUF_RUN);

   always_comb begin
      ram_adr = CARD_NONE;
      ram_din = CARD_NONE;
      ram_we  = 1'b0;
      if (eng_sel) begin
         ram_adr = shuf_adr;
         ram_din = shuf_din;
         ram_we  = shuf_we;
      end else if (state == ST_INIT) begin
         ram_adr = init_cnt;
         ram_din = init_cnt;
         ram_we  = resetn;
      end else if (state == ST_READ) begin
         ram_adr = ptr;
      end
   end

   always_ff @(posedge Clock) begin
      if (!resetn) begin
         state    <= ST_INIT;
         init_cnt <= '0;
         ptr      <= '0;
         gnt_q    <= REQ_PLAYER;
         card_q   <= CARD_NONE;
         empty_q  <= 1'b0;
         left_q   <= FULL_PTR;
      end else begin
         state   <= state_nxt;
         ptr     <= ptr_nxt;
         empty_q <= (ptr_nxt == FULL_PTR);
         left_q  <= FULL_PTR - ptr_nxt;
         if (state == ST_INIT && init_cnt != LAST_ADR)
            init_cnt <= init_cnt + 6'd1;
         if (arb_update)
            gnt_q <= req_id_t'(gnt);
         if (state == ST_WAIT)
            card_q <= ram_dout;
      end
   end

   assign shuf_start = resetn && (state == ST_SHUF_START);
   assign card_valid = (state == ST_DELIVER);
   assign ack_player = card_valid && (gnt_q == REQ_PLAYER);
   assign ack_dealer = card_valid && (gnt_q == REQ_DEALER);
   assign card_out   = card_q;
   assign ready      = (state == ST_IDLE);
   assign deck_empty = empty_q;
   assign cards_left = left_q;

endmodule

// File: tb/tb_deck_controller.sv
// Randomised bench for deck_controller with RAM, shuffle-engine and deck models.
module tb_deck_controller;

   localparam int unsigned DECK = 52;

   logic       Clock = 1'b0;
   logic       resetn;
   logic       shuf_req, shuf_start, shuf_on, shuf_we;
   logic [5:0] shuf_adr, shuf_din;
   logic       req_player, req_dealer, ack_player, ack_dealer;
   logic [5:0] card_out;
   logic       card_valid;
   logic [5:0] ram_adr, ram_din, ram_dout;
   logic       ram_we;
   logic       ready, deck_empty;
   logic [5:0] cards_left;

   always #5 Clock = ~Clock;

   deck_controller #(
      .DECK_SIZE      (DECK),
      .AUTO_RESHUFFLE (0)
   ) dut (
      .Clock      (Clock),
      .resetn     (resetn),
      .shuf_req   (shuf_req),
      .shuf_start (shuf_start),
      .shuf_on    (shuf_on),
      .shuf_adr   (shuf_adr),
      .shuf_din   (shuf_din),
      .shuf_we    (shuf_we),
      .req_player (req_player),
      .req_dealer (req_dealer),
      .ack_player (ack_player),
      .ack_dealer (ack_dealer),
      .card_out   (card_out),
      .card_valid (card_valid),
      .ram_adr    (ram_adr),
      .ram_din    (ram_din),
      .ram_we     (ram_we),
      .ram_dout   (ram_dout),
      .ready      (ready),
      .deck_empty (deck_empty),
      .cards_left (cards_left)
   );

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Synchronous-read deck RAM, read-before-write.
   logic [5:0] mem [64];
   initial begin
      logic [5:0] a, d;
      logic       w;
      for (int i = 0; i < 64; i++) mem[i] = 6'h2A;
      ram_dout = '0;
      forever begin
         @(posedge Clock);
         a = ram_adr; d = ram_din; w = ram_we;
         #1;
         ram_dout = mem[a];
         if (w) mem[a] = d;
      end
   end

   // Shuffle engine stand-in: optional delay, then writes perm[] to 0..DECK-1.
   logic [5:0]  perm [DECK];
   int unsigned eng_phase, eng_cnt, eng_delay;
   initial begin
      shuf_on = 1'b0; shuf_we = 1'b0; shuf_adr = '0; shuf_din = '0;
      eng_phase = 0; eng_cnt = 0;
      forever begin
         @(negedge Clock);
         if (!resetn) begin
            eng_phase = 0; shuf_on = 1'b0; shuf_we = 1'b0;
         end else begin
            case (eng_phase)
               0: if (shuf_start) begin eng_phase = 1; eng_cnt = eng_delay; end
               1: begin
                  if (eng_cnt == 0) begin eng_phase = 2; shuf_on = 1'b1; end
                  else eng_cnt--;
               end
               default: begin
                  if (eng_cnt < DECK) begin
                     shuf_we = 1'b1; shuf_adr = 6'(eng_cnt); shuf_din = perm[eng_cnt]; eng_cnt++;
                  end else begin
                     shuf_we = 1'b0; shuf_on = 1'b0; shuf_adr = 6'h3F; eng_phase = 0;
                  end
               end
            endcase
         end
      end
   end

   // Reference model: deck contents, top-of-deck index, last served, last card.
   logic [5:0]  m_deck [DECK];
   int unsigned m_ptr;
   logic        m_last;
   logic [5:0]  m_card;

   task automatic run_init();
      logic ok;
      resetn = 1'b1;
      #1;
      for (int unsigned i = 0; i < DECK; i++) begin
         check_eq("init_wr", {ram_we, ram_adr, ram_din, ready}, {1'b1, 6'(i), 6'(i), 1'b0});
         tick();
      end
      check_eq("init_ready", ready, 1);
      check_eq("init_bus_idle", {ram_we, ram_adr, ram_din}, {1'b0, 6'h3F, 6'h3F});
      check_eq("init_left", cards_left, DECK);
      check_eq("init_empty", deck_empty, 0);
      #2;
      ok = 1'b1;
      for (int i = 0; i < DECK; i++) if (mem[i] !== 6'(i)) ok = 1'b0;
      check_eq("init_mem", ok, 1);
      for (int i = 0; i < DECK; i++) m_deck[i] = 6'(i);
      m_ptr = 0; m_last = 1'b1; m_card = 6'h3F;
   endtask

   task automatic draw_once(input logic want_p, input logic want_d);
      logic       g;
      logic [5:0] exp_card;
      if (want_p) req_player = 1'b1;
      if (want_d) req_dealer = 1'b1;
      g = (req_player && req_dealer) ? ~m_last : req_dealer;
      exp_card = m_deck[m_ptr];
      tick();
      check_eq("rd_ready", ready, 0);
      check_eq("rd_adr", ram_adr, m_ptr);
      check_eq("rd_we", ram_we, 0);
      tick();
      check_eq("wait_valid", card_valid, 0);
      tick();
      check_eq("dlv_valid", card_valid, 1);
      check_eq("dlv_ack_p", ack_player, (g == 1'b0));
      check_eq("dlv_ack_d", ack_dealer, (g == 1'b1));
      check_eq("dlv_card", card_out, exp_card);
      if (g) req_dealer = 1'b0; else req_player = 1'b0;
      m_last = g; m_ptr++; m_card = exp_card;
      tick();
      check_eq("post_ack", {card_valid, ack_player, ack_dealer}, 0);
      check_eq("post_ready", ready, 1);
      check_eq("cards_left", cards_left, DECK - m_ptr);
      check_eq("deck_empty", deck_empty, (m_ptr == DECK));
   endtask

   task automatic do_shuffle(input logic with_draw, input logic abort);
      logic        seen_on, done;
      int unsigned writes;
      logic [5:0]  tmp;
      int unsigned j;
      for (int i = 0; i < DECK; i++) perm[i] = 6'(i);
      for (int i = DECK - 1; i > 0; i--) begin
         j = $urandom_range(i, 0);
         tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      eng_delay = $urandom_range(3, 0);
      shuf_req = 1'b1;
      if (with_draw) req_player = 1'b1;
      tick();
      check_eq("shuf_start", shuf_start, 1);
      check_eq("shuf_ready", ready, 0);
      shuf_req = 1'b0;
      tick();
      check_eq("shuf_start_pulse", shuf_start, 0);
      seen_on = 1'b0; done = 1'b0; writes = 0;
      for (int unsigned c = 0; c < 400 && !done; c++) begin
         if (seen_on && !shuf_on) begin
            check_eq("shuf_done_ready", ready, 1);
            check_eq("shuf_done_left", cards_left, DECK);
            check_eq("shuf_done_empty", deck_empty, 0);
            done = 1'b1;
         end else begin
            if (shuf_on) seen_on = 1'b1;
            check_eq("shuf_busy", {ready, card_valid, ack_player, ack_dealer}, 0);
            check_eq("shuf_bus", {ram_we, ram_adr, ram_din}, {shuf_we, shuf_adr, shuf_din});
            if (shuf_we) writes++;
            if (abort && writes == 6) begin
               resetn = 1'b0;
               #1;
               check_eq("rst_bus_release", ram_we, 0);
               return;
            end
            tick();
         end
      end
      check_eq("shuf_timeout", done, 1);
      for (int i = 0; i < DECK; i++) m_deck[i] = perm[i];
      m_ptr = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] pat;
      resetn = 1'b0; shuf_req = 1'b0; req_player = 1'b0; req_dealer = 1'b0; eng_delay = 0;
      repeat (3) tick();
      check_eq("rst_card", card_out, 6'h3F);
      check_eq("rst_valid", card_valid, 0);
      check_eq("rst_acks", {ack_player, ack_dealer}, 0);
      check_eq("rst_start", shuf_start, 0);
      check_eq("rst_bus", {ram_we, ram_adr, ram_din}, 0);
      check_eq("rst_ready", ready, 0);
      check_eq("rst_empty", deck_empty, 0);
      check_eq("rst_left", cards_left, DECK);
      run_init();

      // Single player draw, then both held continuously.
      draw_once(1'b1, 1'b0);
      repeat (3) draw_once(1'b1, 1'b1);
      draw_once(1'b0, 1'b0);

      // Shuffle and draw requested in the same IDLE cycle.
      do_shuffle(1'b1, 1'b0);
      draw_once(1'b0, 1'b0);

      // Random draws to an empty deck.
      while (m_ptr < DECK) begin
         if (!req_player && !req_dealer) begin
            repeat ($urandom_range(2, 0)) tick();
            pat = 2'($urandom_range(3, 1));
         end else begin
            pat = 2'($urandom_range(3, 0));
         end
         draw_once(pat[0], pat[1]);
      end

      // Empty deck without auto reshuffle: requests stay pending.
      req_player = 1'b1; req_dealer = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check_eq("empty_hold", {card_valid, ack_player, ack_dealer, shuf_start, ready}, 5'b00001);
         check_eq("empty_card", card_out, m_card);
      end
      check_eq("empty_flag", deck_empty, 1);
      check_eq("empty_left", cards_left, 0);

      do_shuffle(1'b0, 1'b0);
      draw_once(1'b0, 1'b0);
      draw_once(1'b0, 1'b0);

      // Reset in the middle of an engine write burst.
      do_shuffle(1'b0, 1'b1);
      tick();
      check_eq("rst_mid_start", shuf_start, 0);
      check_eq("rst_mid_we", ram_we, 0);
      check_eq("rst_mid_ready", ready, 0);
      check_eq("rst_mid_card", card_out, 6'h3F);
      check_eq("rst_mid_left", cards_left, DECK);
      tick();
      run_init();
      draw_once(1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
